// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a program is streamed in from address 0, then the
// memory serves one-cycle fetches with stall hold, fault reporting and reload.
module instr_mem_loadable #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_done,
  output logic [DEPTH_LOG2:0]   ld_count,
  input  logic                  reload,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  fetch_fault
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {LOAD, RUN} state_t;

  state_t                 state;
  logic [DEPTH_LOG2-1:0]  wptr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  ram_q;
  logic                   ld_fire;
  logic                   last_word;
  logic                   fetch_fire;
  logic                   addr_fault;
  logic [DEPTH_LOG2-1:0]  rd_index;

  assign ld_ready   = (state == LOAD);
  assign ld_fire    = ld_valid && ld_ready && !reload;
  assign last_word  = ld_last || (&wptr);
  assign rd_index   = fetch_addr[DEPTH_LOG2+1:2];
  assign addr_fault = (fetch_addr[1:0] != 2'b00) ||
                      ((fetch_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign fetch_fire = (state == RUN) && fetch_req && !fetch_stall && !reload;

  // ram_q is only loaded by an accepted, non-faulting fetch, so it doubles as the
  // hold register: stalls and faulting fetches never disturb the word it carries.
  assign fetch_instr = (fetch_valid && !fetch_fault) ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem[wptr] <= ld_data;
    end
    if (fetch_fire && !addr_fault) begin
      ram_q <= mem[rd_index];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= LOAD;
      wptr        <= '0;
      ld_count    <= '0;
      ld_done     <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (reload) begin
      state       <= LOAD;
      wptr        <= '0;
      ld_count    <= '0;
      ld_done     <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          fetch_valid <= 1'b0;
          fetch_fault <= 1'b0;
          if (ld_fire) begin
            wptr     <= wptr + 1'b1;
            ld_count <= ld_count + 1'b1;
            // Memory full ends the load even without ld_last, so ld_count tops out at DEPTH.
            if (last_word) begin
              state   <= RUN;
              ld_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!fetch_stall) begin
            fetch_valid <= fetch_req;
            fetch_fault <= fetch_req && addr_fault;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable at DEPTH_LOG2 = 4: load, fetch, stall,
// reload, full memory, faults and asynchronous reset.
module tb_instr_mem_loadable;

  localparam int DW = 32;
  localparam int DL = 4;

  logic          clk;
  logic          rstn;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_done;
  logic [DL:0]   ld_count;
  logic          reload;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_stall;
  logic          fetch_valid;
  logic [DW-1:0] fetch_instr;
  logic          fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_loadable #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rstn(rstn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_done(ld_done), .ld_count(ld_count), .reload(reload),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
    $display("fetch addr=%h valid=%b instr=%h fault=%b", a, fetch_valid, fetch_instr, fetch_fault);
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ld_ready); end
    n_checks++; if (ld_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", ld_done); end
    n_checks++; if (ld_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", ld_count); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
    n_checks++; if (fetch_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", fetch_instr); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b exp 0", fetch_fault); end
    #9;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_load_run;
    load_word(32'h11111111, 1'b0);
    load_word(32'h22222222, 1'b0);
    n_checks++; if (ld_count !== 5'd2) begin n_fail++; $display("FAIL load_count2 got %0d exp 2", ld_count); end
    // A fetch in the cycle that accepts the last word must be ignored.
    fetch_req = 1'b1; fetch_addr = 32'h0;
    load_word(32'h33333333, 1'b1);
    fetch_req = 1'b0;
    n_checks++; if (ld_done !== 1'b1) begin n_fail++; $display("FAIL load_done got %b exp 1", ld_done); end
    n_checks++; if (ld_count !== 5'd3) begin n_fail++; $display("FAIL load_count3 got %0d exp 3", ld_count); end
    n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready got %b exp 0", ld_ready); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_during_last got %b exp 0", fetch_valid); end
    fetch(32'h8);
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid got %b exp 1", fetch_valid); end
    n_checks++; if (fetch_instr !== 32'h33333333) begin n_fail++; $display("FAIL run_instr got %h exp 33333333", fetch_instr); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL run_fault got %b exp 0", fetch_fault); end
    tick();
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", fetch_valid); end
  endtask

  task automatic test_back_to_back;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    n_checks++; if (fetch_instr !== 32'h11111111 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_0 got %b/%h exp 1/11111111", fetch_valid, fetch_instr); end
    fetch_addr = 32'h4;
    tick();
    n_checks++; if (fetch_instr !== 32'h22222222 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_4 got %b/%h exp 1/22222222", fetch_valid, fetch_instr); end
    fetch_addr = 32'h8; fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (fetch_instr !== 32'h22222222 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold%0d got %b/%h exp 1/22222222", i, fetch_valid, fetch_instr); end
    end
    fetch_stall = 1'b0;
    tick();
    n_checks++; if (fetch_instr !== 32'h33333333 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_8 got %b/%h exp 1/33333333", fetch_valid, fetch_instr); end
    fetch_req = 1'b0;
    tick();
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", fetch_valid); end
  endtask

  task automatic test_reload;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h4; reload = 1'b1;
    tick();
    reload = 1'b0; fetch_req = 1'b0;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reload_valid got %b exp 0", fetch_valid); end
    n_checks++; if (ld_done !== 1'b0) begin n_fail++; $display("FAIL reload_done got %b exp 0", ld_done); end
    n_checks++; if (ld_count !== 5'd0) begin n_fail++; $display("FAIL reload_count got %0d exp 0", ld_count); end
    load_word(32'hDEADBEEF, 1'b1);
    n_checks++; if (ld_done !== 1'b1 || ld_count !== 5'd1) begin n_fail++; $display("FAIL reload_load got %b/%0d exp 1/1", ld_done, ld_count); end
    fetch(32'h0);
    n_checks++; if (fetch_instr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reload_f0 got %h exp deadbeef", fetch_instr); end
    fetch(32'h4);
    n_checks++; if (fetch_instr !== 32'h22222222) begin n_fail++; $display("FAIL reload_f4 got %h exp 22222222", fetch_instr); end
  endtask

  task automatic test_full;
    reload = 1'b1; tick(); reload = 1'b0;
    load_word(32'hAAAA0000, 1'b0);
    load_word(32'hAAAA0001, 1'b0);
    reload = 1'b1; tick(); reload = 1'b0;
    n_checks++; if (ld_count !== 5'd0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_reload got %0d/%b exp 0/1", ld_count, ld_ready); end
    for (int i = 0; i < 17; i++) begin
      load_word(32'hF0000000 + i, 1'b0);
      if (i == 15) begin
        n_checks++; if (ld_done !== 1'b1 || ld_ready !== 1'b0 || ld_count !== 5'd16) begin n_fail++; $display("FAIL full_16 got %b/%b/%0d exp 1/0/16", ld_done, ld_ready, ld_count); end
      end
    end
    n_checks++; if (ld_count !== 5'd16 || ld_done !== 1'b1) begin n_fail++; $display("FAIL full_17 got %0d/%b exp 16/1", ld_count, ld_done); end
    fetch(32'h0);
    n_checks++; if (fetch_instr !== 32'hF0000000) begin n_fail++; $display("FAIL full_mem0 got %h exp f0000000", fetch_instr); end
    fetch(32'h3C);
    n_checks++; if (fetch_instr !== 32'hF000000F) begin n_fail++; $display("FAIL full_mem15 got %h exp f000000f", fetch_instr); end
  endtask

  task automatic test_faults;
    fetch(32'h2);
    n_checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b1 || fetch_instr !== 32'h0) begin n_fail++; $display("FAIL fault_misalign got %b/%b/%h exp 1/1/0", fetch_valid, fetch_fault, fetch_instr); end
    fetch(32'h40);
    n_checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b1 || fetch_instr !== 32'h0) begin n_fail++; $display("FAIL fault_range got %b/%b/%h exp 1/1/0", fetch_valid, fetch_fault, fetch_instr); end
    fetch(32'hFFFFFFFC);
    n_checks++; if (fetch_fault !== 1'b1 || fetch_instr !== 32'h0) begin n_fail++; $display("FAIL fault_high got %b/%h exp 1/0", fetch_fault, fetch_instr); end
    fetch(32'h3C);
    n_checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b0 || fetch_instr !== 32'hF000000F) begin n_fail++; $display("FAIL fault_edge got %b/%b/%h exp 1/0/f000000f", fetch_valid, fetch_fault, fetch_instr); end
  endtask

  task automatic test_async_reset;
    fetch_req = 1'b1; fetch_addr = 32'h2;
    tick();
    fetch_stall = 1'b1;
    tick();
    n_checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b1) begin n_fail++; $display("FAIL stall_fault got %b/%b exp 1/1", fetch_valid, fetch_fault); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (fetch_valid !== 1'b0 || fetch_fault !== 1'b0 || fetch_instr !== 32'h0) begin n_fail++; $display("FAIL arst_stall got %b/%b/%h exp 0/0/0", fetch_valid, fetch_fault, fetch_instr); end
    n_checks++; if (ld_done !== 1'b0 || ld_ready !== 1'b1 || ld_count !== 5'd0) begin n_fail++; $display("FAIL arst_stall_ld got %b/%b/%0d exp 0/1/0", ld_done, ld_ready, ld_count); end
    fetch_stall = 1'b0; fetch_req = 1'b0;
    #1 rstn = 1'b1;
    for (int i = 0; i < 5; i++) load_word(32'h50 + i, 1'b0);
    n_checks++; if (ld_count !== 5'd5) begin n_fail++; $display("FAIL midload_count got %0d exp 5", ld_count); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (ld_count !== 5'd0 || ld_ready !== 1'b1 || ld_done !== 1'b0) begin n_fail++; $display("FAIL arst_load got %0d/%b/%b exp 0/1/0", ld_count, ld_ready, ld_done); end
    #1 rstn = 1'b1;
    load_word(32'h12345678, 1'b1);
    n_checks++; if (ld_count !== 5'd1 || ld_done !== 1'b1) begin n_fail++; $display("FAIL arst_reload got %0d/%b exp 1/1", ld_count, ld_done); end
    fetch(32'h0);
    n_checks++; if (fetch_instr !== 32'h12345678) begin n_fail++; $display("FAIL arst_f0 got %h exp 12345678", fetch_instr); end
    fetch(32'h4);
    n_checks++; if (fetch_instr !== 32'h00000051) begin n_fail++; $display("FAIL arst_f4 got %h exp 00000051", fetch_instr); end
    fetch(32'h14);
    n_checks++; if (fetch_instr !== 32'hF0000005) begin n_fail++; $display("FAIL arst_f14 got %h exp f0000005", fetch_instr); end
  endtask

  initial begin
    rstn = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    test_reset();
    test_load_run();
    test_back_to_back();
    test_reload();
    test_full();
    test_faults();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
